// File: rtl/csa_pkg.sv
// Shared types and constants for the byte-serial adder and its 8-bit datapath.
package csa_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } bsa_state_t;

endpackage

// File: rtl/conditional_sum_adder.sv
// 8-bit conditional-sum adder: upper nibble pre-computed for both carries, selected by the low-nibble carry.
module conditional_sum_adder (
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       cin,
  output logic [7:0] correctSum,
  output logic       cout
);

  logic [4:0] lo_sum;
  logic [4:0] hi_sum0;
  logic [4:0] hi_sum1;

  always_comb begin
    lo_sum  = {1'b0, x[3:0]} + {1'b0, y[3:0]} + {4'b0000, cin};
    hi_sum0 = {1'b0, x[7:4]} + {1'b0, y[7:4]};
    hi_sum1 = {1'b0, x[7:4]} + {1'b0, y[7:4]} + 5'd1;
    correctSum[3:0] = lo_sum[3:0];
    if (lo_sum[4]) begin
      correctSum[7:4] = hi_sum1[3:0];
      cout            = hi_sum1[4];
    end else begin
      correctSum[7:4] = hi_sum0[3:0];
      cout            = hi_sum0[4];
    end
  end

endmodule

// File: rtl/byte_serial_adder.sv
// Wide adder that streams operands LSB byte first through one 8-bit adder,
// chaining each byte's carry-out into the next byte over successive cycles.
module byte_serial_adder
  import csa_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [BYTE_W*NBYTES-1:0]   in_a,
  input  logic [BYTE_W*NBYTES-1:0]   in_b,
  input  logic                       in_cin,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [BYTE_W*NBYTES-1:0]   out_sum,
  output logic                       out_cout,
  output logic                       out_ovf
);

  localparam int W     = BYTE_W * NBYTES;
  localparam int CNT_W = $clog2(NBYTES + 1);

  bsa_state_t       state_q, state_d;
  logic [W-1:0]     a_sh_q, a_sh_d;
  logic [W-1:0]     b_sh_q, b_sh_d;
  logic [W-1:0]     result_q, result_d;
  logic [W-1:0]     result_shift;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [BYTE_W-1:0] sum8;
  logic              cout8;

  conditional_sum_adder u_csa (
    .x          (a_sh_q[BYTE_W-1:0]),
    .y          (b_sh_q[BYTE_W-1:0]),
    .cin        (carry_q),
    .correctSum (sum8),
    .cout       (cout8)
  );

  // Result fills from the top so the first (LSB) byte ends up at the bottom after NBYTES shifts.
  generate
    if (NBYTES == 1) begin : g_res_one
      assign result_shift = sum8;
    end else begin : g_res_many
      assign result_shift = {sum8, result_q[W-1:BYTE_W]};
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = in_a;
          b_sh_d  = in_b;
          carry_d = in_cin;
          cnt_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        a_sh_d   = a_sh_q >> BYTE_W;
        b_sh_d   = b_sh_q >> BYTE_W;
        result_d = result_shift;
        carry_d  = cout8;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(NBYTES - 1)) begin
          ovf_d   = (a_sh_q[BYTE_W-1] == b_sh_q[BYTE_W-1]) &&
                    (sum8[BYTE_W-1] != a_sh_q[BYTE_W-1]);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_sum   = result_q;
  assign out_cout  = carry_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_byte_serial_adder.sv
// Directed and random checks of byte_serial_adder at NBYTES=4, NBYTES=1 and NBYTES=8.
module tb_byte_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        in_valid = 1'b0, in_cin = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, out_cout, out_ovf;
  logic [31:0] in_a = '0, in_b = '0, out_sum;

  logic        s1_in_valid = 1'b0, s1_in_cin = 1'b0, s1_out_ready = 1'b0;
  logic        s1_in_ready, s1_out_valid, s1_out_cout, s1_out_ovf;
  logic [7:0]  s1_in_a = '0, s1_in_b = '0, s1_out_sum;

  logic        s8_in_valid = 1'b0, s8_in_cin = 1'b0, s8_out_ready = 1'b0;
  logic        s8_in_ready, s8_out_valid, s8_out_cout, s8_out_ovf;
  logic [63:0] s8_in_a = '0, s8_in_b = '0, s8_out_sum;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  byte_serial_adder #(.NBYTES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
  );

  byte_serial_adder #(.NBYTES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(s1_in_valid), .in_ready(s1_in_ready),
    .in_a(s1_in_a), .in_b(s1_in_b), .in_cin(s1_in_cin), .out_valid(s1_out_valid),
    .out_ready(s1_out_ready), .out_sum(s1_out_sum), .out_cout(s1_out_cout), .out_ovf(s1_out_ovf)
  );

  byte_serial_adder #(.NBYTES(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(s8_in_valid), .in_ready(s8_in_ready),
    .in_a(s8_in_a), .in_b(s8_in_b), .in_cin(s8_in_cin), .out_valid(s8_out_valid),
    .out_ready(s8_out_ready), .out_sum(s8_out_sum), .out_cout(s8_out_cout), .out_ovf(s8_out_ovf)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op on the 4-byte instance; hold out_ready low for 'hold' cycles once valid.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input int hold, output logic [31:0] s, output logic co,
                        output logic ov, output int lat);
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    repeat (hold) tick();
    s = out_sum; co = out_cout; ov = out_ovf;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  vec_t        vecs[7];
  logic [31:0] s, ref_sum;
  logic [63:0] s8_ref;
  logic [32:0] wide;
  logic [64:0] wide8;
  logic [8:0]  w1;
  logic        co, ov, ref_ov;
  int          lat;

  initial begin
    vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
    vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[3] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vecs[4] = '{32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0, 1'b0};
    vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[6] = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1};

    // Reset state, sampled while rst_n is still low
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_cout", out_cout, 0);
    chk("rst_out_ovf", out_ovf, 0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, 0, s, co, ov, lat);
      chk($sformatf("vec%0d_sum", i), s, vecs[i].sum);
      chk($sformatf("vec%0d_cout", i), co, vecs[i].cout);
      chk($sformatf("vec%0d_ovf", i), ov, vecs[i].ovf);
      chk($sformatf("vec%0d_latency", i), lat, 4);
      chk($sformatf("vec%0d_idle_after", i), {out_valid, in_ready}, 2'b01);
    end

    // Backpressure: result held for 10 cycles, in_valid pulses ignored
    in_a = 32'h00001111; in_b = 32'h00002222; in_cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    for (int c = 0; c < 10; c++) begin
      in_a = 32'hDEADBEEF; in_b = 32'h01020304; in_valid = c[0];
      tick();
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_sum", out_sum, 32'h00003334);
      chk("bp_cout_ovf", {out_cout, out_ovf}, 2'b00);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_in_ready", in_ready, 1);
    repeat (6) tick();
    chk("bp_nothing_latched", {out_valid, in_ready}, 2'b01);

    // in_ready stays low in DONE even when out_ready is high in the same cycle
    in_a = 32'd5; in_b = 32'd6; in_cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    out_ready = 1'b1;
    tick();
    chk("done_ready_in_ready", {out_valid, in_ready}, 2'b10);
    tick();
    out_ready = 1'b0;
    chk("done_ready_idle", {out_valid, in_ready}, 2'b01);

    // Reset during the second ADD cycle
    in_a = 32'hFFFFFFFF; in_b = 32'h00000001; in_cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {out_valid, out_sum, out_cout, out_ovf}, 35'd0);
    chk("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("midrst_release_in_ready", in_ready, 1);
    chk("midrst_no_valid", out_valid, 0);
    run_op(32'd1, 32'd2, 1'b0, 0, s, co, ov, lat);
    chk("midrst_next_sum", s, 32'd3);
    chk("midrst_next_flags", {co, ov}, 2'b00);

    // Random ops with random handshake gaps against an integer model
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a, b;
      logic        c;
      a = $urandom; b = $urandom; c = 1'(($urandom));
      if (n % 4 == 0) b = ~a;
      wide = {1'b0, a} + {1'b0, b} + {32'd0, c};
      ref_sum = wide[31:0];
      ref_ov = (a[31] == b[31]) && (ref_sum[31] != a[31]);
      repeat ($urandom_range(0, 2)) tick();
      run_op(a, b, c, $urandom_range(0, 3), s, co, ov, lat);
      chk("rnd_sum", s, ref_sum);
      chk("rnd_cout_ovf", {co, ov}, {wide[32], ref_ov});
      chk("rnd_latency", lat, 4);
    end

    // NBYTES=1: single-cycle ADD
    for (int n = 0; n < 64; n++) begin
      s1_in_a = 8'($urandom); s1_in_b = 8'($urandom); s1_in_cin = 1'(($urandom));
      if (n == 0) begin s1_in_a = 8'h7F; s1_in_b = 8'h00; s1_in_cin = 1'b1; end
      w1 = {1'b0, s1_in_a} + {1'b0, s1_in_b} + {8'd0, s1_in_cin};
      s1_in_valid = 1'b1;
      tick();
      s1_in_valid = 1'b0;
      chk("nb1_busy", {s1_out_valid, s1_in_ready}, 2'b00);
      tick();
      chk("nb1_valid", s1_out_valid, 1);
      chk("nb1_sum", s1_out_sum, w1[7:0]);
      chk("nb1_cout_ovf", {s1_out_cout, s1_out_ovf},
          {w1[8], (s1_in_a[7] == s1_in_b[7]) && (w1[7] != s1_in_a[7])});
      s1_out_ready = 1'b1;
      tick();
      s1_out_ready = 1'b0;
    end

    // NBYTES=8: eight-cycle ADD
    for (int n = 0; n < 64; n++) begin
      int l8;
      s8_in_a = {$urandom, $urandom}; s8_in_b = {$urandom, $urandom}; s8_in_cin = 1'(($urandom));
      if (n == 0) begin s8_in_a = '1; s8_in_b = '0; s8_in_cin = 1'b1; end
      wide8 = {1'b0, s8_in_a} + {1'b0, s8_in_b} + {64'd0, s8_in_cin};
      s8_ref = wide8[63:0];
      s8_in_valid = 1'b1;
      tick();
      s8_in_valid = 1'b0;
      l8 = 0;
      while (!s8_out_valid && l8 < 20) begin
        tick();
        l8++;
      end
      chk("nb8_latency", l8, 8);
      chk("nb8_sum", s8_out_sum, s8_ref);
      chk("nb8_cout_ovf", {s8_out_cout, s8_out_ovf},
          {wide8[64], (s8_in_a[63] == s8_in_b[63]) && (s8_ref[63] != s8_in_a[63])});
      s8_out_ready = 1'b1;
      tick();
      s8_out_ready = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
